serial_excess_converter: RTL and testbench

Parametrised, bit-serial, LSB-first code converter between an offset code (Excess-K) and plain BCD-style values, one W-bit code word per frame. It generalises the 4-bit Excess-3 to BCD Mealy converter in four ways:
- configurable width and offset;
- a per-frame direction mode (subtract or add offset);
- a Valid qualifier that lets the stream stall;
- registered frame-done and invalid-code flags.

It sits between a serial bit source and a serial sink, with Z produced in the same cycle as X.

---
 rtl/serial_excess_converter.sv | 111 +++++++++++
 tb/tb_serial_excess_converter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_excess_converter.sv
// Bit-serial, LSB-first Excess-K <-> plain code converter.
// One W-bit code word per frame. Mode (sampled at bit 0) selects subtract K
// (Excess-K -> plain) or add K (plain -> Excess-K). Z is a Mealy output of
// the current X. Done pulses one cycle after a frame's last bit; Err pulses
// with it when that frame's input word was an illegal code.
module serial_excess_converter #(
  parameter int W    = 4,
  parameter int K    = 3,
  parameter int MAXV = 9
) (
  input  logic Clk,
  input  logic Rst,
  input  logic X,
  input  logic Valid,
  input  logic Mode,
  output logic Z,
  output logic Done,
  output logic Err
);

  localparam int CW = $clog2(W);

  localparam logic [W-1:0]  K_VEC    = W'(K);
  localparam logic [W-1:0]  MAXV_VEC = W'(MAXV);
  localparam logic [W-1:0]  KMAX_VEC = W'(K + MAXV);
  localparam logic [CW-1:0] LAST     = CW'(W - 1);

  logic [CW-1:0] cnt;
  logic          c_q;
  logic          m_q;
  // Bit W-1 is never stored: on its edge it is taken straight from X.
  logic [W-2:0]  in_q;

  logic          mode_eff;
  logic          c_eff;
  logic          k_bit;
  logic          c_next;
  logic [W-1:0]  word;
  logic          word_bad;

  // Serial add/subtract of the offset bit plus carry/borrow, and code check.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    mode_eff = Mode;
    c_eff    = 1'b0;
    k_bit    = K_VEC[cnt];
    c_next   = 1'b0;
    word     = {X, in_q};
    word_bad = 1'b0;

    // Bit 0 starts a fresh frame: take Mode live and ignore the stale carry.
    if (cnt != '0) begin
      mode_eff = m_q;
      c_eff    = c_q;
    end

    Z = X ^ k_bit ^ c_eff;

    if (mode_eff) begin
      c_next = (X & k_bit) | (X & c_eff) | (k_bit & c_eff);
    end else begin
      c_next = (~X & (k_bit | c_eff)) | (k_bit & c_eff);
    end

    // Only meaningful on the last bit, where the latched mode applies.
    if (m_q) begin
      word_bad = (word > MAXV_VEC);
    end else begin
      word_bad = (word < K_VEC) || (word > KMAX_VEC);
    end
  end

  // Bit counter, carry, mode latch, input capture and the Done/Err pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      // NOTE: the capture register is reset along with the control state so a
      // frame aborted by reset leaves no stale bits behind.
      cnt  <= '0;
      c_q  <= 1'b0;
      m_q  <= 1'b0;
      in_q <= '0;
      Done <= 1'b0;
      Err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, independent of statement order.
      Done <= 1'b0;
      Err  <= 1'b0;
      if (Valid) begin
        c_q <= c_next;
        if (cnt == '0) begin
          m_q <= Mode;
        end
        for (int i = 0; i < W - 1; i++) begin
          if (cnt == CW'(i)) begin
            in_q[i] <= X;
          end
        end
        if (cnt == LAST) begin
          cnt  <= '0;
          Done <= 1'b1;
          Err  <= word_bad;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_excess_converter.sv
// Bench for serial_excess_converter: a default 4-bit Excess-3 instance and an
// 8-bit Excess-51 instance, driven by directed frames. An arithmetic model
// checks Z, Done and Err every cycle; literal expectations pin the model.
module tb_serial_excess_converter;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  logic x4 = 1'b0, valid4 = 1'b0, mode4 = 1'b0;
  logic z4, done4, err4;
  logic x8 = 1'b0, valid8 = 1'b0, mode8 = 1'b0;
  logic z8, done8, err8;

  int n_cmp = 0;
  int n_bad = 0;
  bit rst_hit = 1'b0;

  always #5 Clk = ~Clk;

  serial_excess_converter dut4 (
    .Clk(Clk), .Rst(Rst), .X(x4), .Valid(valid4), .Mode(mode4),
    .Z(z4), .Done(done4), .Err(err4)
  );

  serial_excess_converter #(.W(8), .K(51), .MAXV(99)) dut8 (
    .Clk(Clk), .Rst(Rst), .X(x8), .Valid(valid8), .Mode(mode8),
    .Z(z8), .Done(done8), .Err(err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the bits received so far as an integer; bit i of the result is
  // bit i of (received_value +/- K), since carries only ripple upward.
  typedef struct {
    int cnt;
    int acc;
    bit m;
    bit done;
    bit err;
  } mstate_t;

  mstate_t ms4, ms8;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.cnt = 0; s.acc = 0; s.m = 1'b0; s.done = 1'b0; s.err = 1'b0;
    return s;
  endfunction

  function automatic int m_acc(mstate_t s, bit x);
    int base = (s.cnt == 0) ? 0 : s.acc;
    return base | (int'(x) << s.cnt);
  endfunction

  function automatic bit m_z(mstate_t s, bit x, bit mode, int k);
    bit md  = (s.cnt == 0) ? mode : s.m;
    int acc = m_acc(s, x);
    int val = md ? acc + k : acc - k;
    return bit'((val >> s.cnt) & 1);
  endfunction

  function automatic mstate_t m_step(mstate_t s, bit x, bit v, bit mode,
                                     int w, int k, int maxv);
    mstate_t n = s;
    bit md;
    int acc;
    n.done = 1'b0;
    n.err  = 1'b0;
    if (v) begin
      md  = (s.cnt == 0) ? mode : s.m;
      acc = m_acc(s, x);
      n.m = md;
      if (s.cnt == w - 1) begin
        n.done = 1'b1;
        n.err  = md ? (acc > maxv) : (acc < k || acc > k + maxv);
        n.cnt  = 0;
        n.acc  = 0;
      end else begin
        n.cnt = s.cnt + 1;
        n.acc = acc;
      end
    end
    return n;
  endfunction

  always @(negedge Rst) rst_hit = 1'b1;

  // Compare process: outputs checked mid-cycle; inputs are stable from here
  // to the next rising edge, so the model then advances by one edge.
  always @(negedge Clk) begin
    if (!Rst || rst_hit) begin
      ms4 = m_reset();
      ms8 = m_reset();
      rst_hit = 1'b0;
    end
    if (Rst) begin
      if (valid4) check("z4", 32'(z4), 32'(m_z(ms4, x4, mode4, 3)));
      check("done4", 32'(done4), 32'(ms4.done));
      check("err4",  32'(err4),  32'(ms4.err));
      if (valid8) check("z8", 32'(z8), 32'(m_z(ms8, x8, mode8, 51)));
      check("done8", 32'(done8), 32'(ms8.done));
      check("err8",  32'(err8),  32'(ms8.err));
      ms4 = m_step(ms4, x4, valid4, mode4, 4, 3, 9);
      ms8 = m_step(ms8, x8, valid8, mode8, 8, 51, 99);
    end
  end

  // ---------------- drivers ----------------
  // Drive one cycle on the 4-bit instance; returns Z sampled mid-cycle.
  task automatic cyc4(input logic x, input logic v, input logic md, output logic z);
    x4 = x; valid4 = v; mode4 = md;
    @(negedge Clk);
    z = z4;
    @(posedge Clk);
    #1;
  endtask

  task automatic frame4(input logic [3:0] bits, input logic md, output logic [3:0] zs);
    for (int i = 0; i < 4; i++) cyc4(bits[i], 1'b1, md, zs[i]);
    valid4 = 1'b0;
  endtask

  task automatic frame8(input logic [7:0] bits, input logic md, output logic [7:0] zs);
    for (int i = 0; i < 8; i++) begin
      x8 = bits[i]; valid8 = 1'b1; mode8 = md;
      @(negedge Clk);
      zs[i] = z8;
      @(posedge Clk);
      #1;
    end
    valid8 = 1'b0;
  endtask

  logic [3:0] zs4;
  logic [7:0] zs8;
  logic       zb;

  initial begin
    // Reset state: Z follows X ^ K[0] combinationally.
    #1;
    check("rst_z4", 32'(z4), 32'd1);
    check("rst_z8", 32'(z8), 32'd1);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_err4", 32'(err4), 32'd0);
    x4 = 1'b1;
    #1;
    check("rst_z4_x1", 32'(z4), 32'd0);
    x4 = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Rst = 1'b1;

    // XS3 7 -> 4
    frame4(4'd7, 1'b0, zs4);
    check("xs3_7_z", 32'(zs4), 32'd4);
    check("xs3_7_done", 32'(done4), 32'd1);
    check("xs3_7_err", 32'(err4), 32'd0);

    // 9 -> 12, then 0 -> 3 back-to-back
    frame4(4'd9, 1'b1, zs4);
    check("add_9_z", 32'(zs4), 32'd12);
    check("add_9_err", 32'(err4), 32'd0);
    check("add_9_done", 32'(done4), 32'd1);
    frame4(4'd0, 1'b1, zs4);
    check("add_0_z", 32'(zs4), 32'd3);
    check("add_0_done", 32'(done4), 32'd1);
    cyc4(1'b0, 1'b0, 1'b0, zb);
    check("idle_done", 32'(done4), 32'd0);

    // Illegal codes
    frame4(4'd14, 1'b0, zs4);
    check("sub_14_z", 32'(zs4), 32'd11);
    check("sub_14_err", 32'(err4), 32'd1);
    frame4(4'd1, 1'b0, zs4);
    check("sub_1_z", 32'(zs4), 32'd14);
    check("sub_1_err", 32'(err4), 32'd1);
    frame4(4'd10, 1'b1, zs4);
    check("add_10_z", 32'(zs4), 32'd13);
    check("add_10_err", 32'(err4), 32'd1);
    cyc4(1'b0, 1'b0, 1'b0, zb);
    check("err_clears", 32'(err4), 32'd0);

    // Stall between bits 1 and 2, Mode toggling while stalled
    cyc4(1'b1, 1'b1, 1'b0, zs4[0]);
    cyc4(1'b1, 1'b1, 1'b0, zs4[1]);
    cyc4(1'b0, 1'b0, 1'b1, zb);
    cyc4(1'b1, 1'b0, 1'b0, zb);
    cyc4(1'b0, 1'b0, 1'b1, zb);
    check("stall_no_done", 32'(done4), 32'd0);
    cyc4(1'b1, 1'b1, 1'b1, zs4[2]);
    cyc4(1'b0, 1'b1, 1'b1, zs4[3]);
    valid4 = 1'b0;
    check("stall_z", 32'(zs4), 32'd4);
    check("stall_done", 32'(done4), 32'd1);
    check("stall_err", 32'(err4), 32'd0);

    // Reset mid-frame: two bits, then an asynchronous pulse between edges
    cyc4(1'b1, 1'b1, 1'b0, zb);
    cyc4(1'b1, 1'b1, 1'b0, zb);
    valid4 = 1'b0;
    #1 Rst = 1'b0;
    #1 Rst = 1'b1;
    @(negedge Clk);
    check("rst_mid_done", 32'(done4), 32'd0);
    check("rst_mid_err", 32'(err4), 32'd0);
    @(posedge Clk);
    #1;
    frame4(4'd7, 1'b0, zs4);
    check("after_rst_z", 32'(zs4), 32'd4);
    check("after_rst_done", 32'(done4), 32'd1);

    // 8-bit Excess-51 instance
    frame8(8'd100, 1'b1, zs8);
    check("w8_100_z", 32'(zs8), 32'd151);
    check("w8_100_err", 32'(err8), 32'd1);
    frame8(8'd99, 1'b1, zs8);
    check("w8_99_z", 32'(zs8), 32'd150);
    check("w8_99_err", 32'(err8), 32'd0);
    check("w8_99_done", 32'(done8), 32'd1);
    frame8(8'd150, 1'b0, zs8);
    check("w8_sub_150_z", 32'(zs8), 32'd99);
    check("w8_sub_150_err", 32'(err8), 32'd0);
    frame8(8'd50, 1'b0, zs8);
    check("w8_sub_50_z", 32'(zs8), 32'd255);
    check("w8_sub_50_err", 32'(err8), 32'd1);

    repeat (2) @(posedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
